aram_fifo_ctl_64x513: RTL and testbench

Sequencing controller that turns a 64-entry x 513-bit single-clock 1R1W block RAM into an in-order valid/ready FIFO for the host flit datapath. It drives the RAM's write and read ports, hides the RAM's one-cycle registered read latency behind a 2-entry output skid, and returns one credit per dequeued entry. The RAM is instantiated beside this block at the next level up; this block owns all addressing and enables.

---
 rtl/aram_fifo_ctl_64x513_pkg.sv | 8 +
 rtl/aram_fifo_skid2.sv | 48 ++++
 rtl/aram_fifo_ctl_64x513.sv | 108 ++++++++++
 tb/tb_aram_fifo_ctl_64x513.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aram_fifo_ctl_64x513_pkg.sv
// Shared sizing constants for the 64x513 block-RAM FIFO controller and its skid buffer.
package aram_fifo_ctl_64x513_pkg;
  localparam int FIFO_DEPTH = 64;
  localparam int FIFO_AW    = 6;
  localparam int FIFO_DW    = 513;
  // Occupancy counter width: holds 0..66 (RAM + in-flight read + skid).
  localparam int FIFO_CW    = 7;
endpackage

// File: rtl/aram_fifo_skid2.sv
// Two-entry ordered skid buffer that absorbs the RAM's registered read data
// so the FIFO head can be held stable under backpressure.
module aram_fifo_skid2
  import aram_fifo_ctl_64x513_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_pushData,
  input  logic          i_pop,
  output logic [DW-1:0] o_headData,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_mem [2];
  logic          r_head;
  logic [1:0]    r_cnt;
  logic          w_tail;

  // With two slots the tail is head+cnt mod 2; a push into a full buffer
  // only happens alongside a pop, so it safely reuses the departing slot.
  assign w_tail     = r_head ^ r_cnt[0];
  assign o_headData = r_mem[r_head];
  assign o_cnt      = r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_flush) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (i_pop)
        r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[w_tail] <= i_pushData;
  end

endmodule

// File: rtl/aram_fifo_ctl_64x513.sv
// In-order valid/ready FIFO controller around an external 64x513 1R1W block RAM
// with one-cycle read latency, hidden behind a 2-entry skid; one credit per dequeue.
module aram_fifo_ctl_64x513
  import aram_fifo_ctl_64x513_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DW-1:0]      wr_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [DW-1:0]      rd_data,
  output logic [FIFO_CW-1:0] count,
  output logic               credit,
  output logic               ram_ena,
  output logic               ram_wea,
  output logic [AW-1:0]      ram_addra,
  output logic [DW-1:0]      ram_dia,
  output logic               ram_enb,
  output logic [AW-1:0]      ram_addrb,
  input  logic [DW-1:0]      ram_dob
);

  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [FIFO_CW-1:0] r_ramCnt;
  logic               r_inflight;
  logic               r_wrReady;

  logic               w_enq;
  logic               w_pop;
  logic               w_issue;
  logic               w_skidPush;
  logic [1:0]         w_skidCnt;
  logic [2:0]         w_occ;
  logic [2:0]         w_limit;
  logic [FIFO_CW-1:0] w_ramCntNext;

  assign w_pop   = rd_valid & rd_ready;
  assign w_enq   = wr_valid & r_wrReady & ~flush;
  // Issue only if the skid can still take the returning word after this cycle's pop.
  assign w_occ   = {1'b0, w_skidCnt} + {2'b00, r_inflight};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign w_issue = ~flush & (r_ramCnt != '0) & (w_occ < w_limit);
  assign w_skidPush = r_inflight & ~flush;

  always_comb begin
    w_ramCntNext = r_ramCnt;
    if (flush)
      w_ramCntNext = '0;
    else if (w_enq && !w_issue)
      w_ramCntNext = r_ramCnt + 1'b1;
    else if (!w_enq && w_issue)
      w_ramCntNext = r_ramCnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ramCnt   <= '0;
      r_inflight <= 1'b0;
      r_wrReady  <= 1'b0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_enq)
          r_wptr <= r_wptr + 1'b1;
        if (w_issue)
          r_rptr <= r_rptr + 1'b1;
      end
      r_ramCnt   <= w_ramCntNext;
      r_inflight <= w_issue;
      r_wrReady  <= (w_ramCntNext != FIFO_CW'(DEPTH)) & ~flush;
    end
  end

  aram_fifo_skid2 #(.DW(DW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_push     (w_skidPush),
    .i_pushData (ram_dob),
    .i_pop      (w_pop),
    .o_headData (rd_data),
    .o_cnt      (w_skidCnt)
  );

  assign wr_ready  = r_wrReady;
  assign rd_valid  = (w_skidCnt != 2'd0);
  assign credit    = w_pop;
  assign count     = r_ramCnt + FIFO_CW'(r_inflight) + FIFO_CW'(w_skidCnt);
  assign ram_ena   = w_enq;
  assign ram_wea   = w_enq;
  assign ram_addra = r_wptr;
  assign ram_dia   = wr_data;
  assign ram_enb   = w_issue;
  assign ram_addrb = r_rptr;

endmodule

// File: tb/tb_aram_fifo_ctl_64x513.sv
// Self-checking bench: a queue-based FIFO model fed from observed write handshakes,
// an independent monitor that pops and compares on every read handshake.
module tb_aram_fifo_ctl_64x513;

  localparam int DW = 513;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [6:0]    count;
  logic          credit;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dob;

  logic [DW-1:0] ramModel [64];
  logic [DW-1:0] expQ [$];
  int            checks = 0;
  int            errors = 0;
  int            popCount = 0;
  int            cycle = 0;
  logic          prevHold = 1'b0;
  logic [DW-1:0] prevData;

  aram_fifo_ctl_64x513 dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .credit    (credit),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  always #5 clk = ~clk;

  // Behavioural block RAM with registered read port, as instantiated beside the controller.
  always @(posedge clk) begin
    cycle++;
    if (ram_ena && ram_wea)
      ramModel[ram_addra] <= ram_dia;
    if (ram_enb)
      ram_dob <= ramModel[ram_addrb];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    logic [543:0] t;
    for (int i = 0; i < 17; i++)
      t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  // Monitor: count must equal accepted-minus-dequeued, pops must follow enqueue order.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
      prevHold = 1'b0;
    end else begin
      checkOutput("count", DW'(count), DW'(expQ.size()));
      if (prevHold) begin
        checkOutput("holdValid", DW'(rd_valid), DW'(1));
        checkOutput("holdData", rd_data, prevData);
      end
      if (rd_valid && rd_ready) begin
        popCount++;
        checkOutput("creditPulse", DW'(credit), DW'(1));
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPop: got %0h expected no entry", rd_data);
        end else begin
          checkOutput("rdData", rd_data, expQ.pop_front());
        end
      end else begin
        checkOutput("creditIdle", DW'(credit), DW'(0));
      end
      prevHold = rd_valid & ~rd_ready;
      prevData = rd_data;
      if (flush) begin
        expQ.delete();
        prevHold = 1'b0;
      end else if (wr_valid && wr_ready) begin
        expQ.push_back(wr_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    tick();
  endtask

  // Single write into an empty FIFO; measures cycles until rd_valid appears.
  task automatic writeAndMeasure(input logic [DW-1:0] d, input string name);
    int lat;
    wr_valid = 1'b1;
    wr_data  = d;
    rd_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, "WrReady"}, DW'(wr_ready), DW'(1));
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rd_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "Latency"}, DW'(lat), DW'(3));
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while ((count != 0 || rd_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "Drained"}, DW'(n < 300), DW'(1));
    tick();
  endtask

  task automatic randomTraffic(input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'($urandom_range(0, 1)), randData(), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted, attempts, base, start;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstWrReady", DW'(wr_ready), DW'(0));
    checkOutput("rstRdValid", DW'(rd_valid), DW'(0));
    checkOutput("rstCount", DW'(count), DW'(0));
    checkOutput("rstCredit", DW'(credit), DW'(0));
    checkOutput("rstRamEn", DW'({ram_ena, ram_wea, ram_enb}), DW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("relWrReadyLow", DW'(wr_ready), DW'(0));
    tick();
    checkOutput("relWrReadyHigh", DW'(wr_ready), DW'(1));

    // First-word latency with data 0x1.
    writeAndMeasure(DW'(1), "first");
    repeat (2) tick();

    // Fill to capacity with rd_ready low, then drain in order.
    rd_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 70; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(accepted);
      @(negedge clk);
      if (wr_ready)
        accepted++;
      tick();
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    checkOutput("fillAccepted", DW'(accepted), DW'(66));
    checkOutput("fillWrReady", DW'(wr_ready), DW'(0));
    checkOutput("fillCount", DW'(count), DW'(66));
    base = popCount;
    drain("fill");
    checkOutput("fillCredits", DW'(popCount - base), DW'(66));

    // Back-to-back streaming of 200 entries.
    base = popCount;
    attempts = 0;
    accepted = 0;
    start = cycle;
    rd_ready = 1'b1;
    while (accepted < 200 && attempts < 400) begin
      wr_valid = 1'b1;
      wr_data  = randData();
      @(negedge clk);
      if (wr_ready)
        accepted++;
      attempts++;
      tick();
    end
    wr_valid = 1'b0;
    checkOutput("streamNoStall", DW'(attempts), DW'(200));
    for (int i = 0; i < 50 && popCount - base < 200; i++)
      tick();
    checkOutput("streamPops", DW'(popCount - base), DW'(200));
    checkOutput("streamRate", DW'(cycle - start <= 206), DW'(1));

    // Random valid/ready traffic.
    randomTraffic(600);
    drain("random");

    // Flush right after a read issue while the skid is full.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, randData(), 1'b0);
    wr_valid = 1'b0;
    repeat (4) tick();
    checkOutput("preFlushCount", DW'(count), DW'(5));
    rd_ready = 1'b1;
    tick();
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = DW'('hDEAD);
    @(negedge clk);
    checkOutput("flushNoIssue", DW'(ram_enb), DW'(0));
    checkOutput("flushNoWrite", DW'(ram_ena), DW'(0));
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    checkOutput("postFlushCount", DW'(count), DW'(0));
    checkOutput("postFlushValid", DW'(rd_valid), DW'(0));
    tick();
    writeAndMeasure(DW'('hABC), "afterFlush");
    drain("flush");

    // Reset in the middle of traffic.
    randomTraffic(40);
    reset    = 1'b1;
    wr_valid = 1'b0;
    #1;
    checkOutput("midRstWrReady", DW'(wr_ready), DW'(0));
    checkOutput("midRstRdValid", DW'(rd_valid), DW'(0));
    checkOutput("midRstCount", DW'(count), DW'(0));
    checkOutput("midRstCredit", DW'(credit), DW'(0));
    checkOutput("midRstRamEn", DW'({ram_ena, ram_enb}), DW'(0));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checkOutput("midRelWrReady", DW'(wr_ready), DW'(1));
    randomTraffic(150);
    drain("afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
